// File: rtl/xeng_ctrl_pkg.sv
// xeng_ctrl shared definitions: control register map,
// CTRL/STATUS bit positions and FSM state encodings.
package xeng_ctrl_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_CYCLES = 2'd1;
    localparam logic [1:0] REG_RUNS   = 2'd2;
    localparam logic [1:0] REG_ZERO   = 2'd3;

    localparam int CTRL_RUN = 0;
    localparam int CTRL_CLR = 1;

    localparam int ST_DONE = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_PEND = 2;
    localparam int ST_OVF  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/xeng_ctrl_xsat_cnt.sv
// Saturating up-counter; clr loads 1 and wins over en.
module xsat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= CNT_W'(1);
        end else if (en && !(&q)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/xeng_ctrl.sv
// Host-facing engine controller: memory decode, control
// registers, run launch with one-deep queued request.
module xeng_ctrl
    import xeng_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DATAPATH_W = 16,
    parameter int N_MEM      = 4,
    parameter int NMEM_W     = 2,
    parameter int MEM_ADDR_W = 10,
    parameter int N_DONE     = 4,
    parameter int CONF_W     = 256,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid,
    input  logic                        we,
    input  logic [NMEM_W+MEM_ADDR_W:0]  addr,
    input  logic [DATA_W-1:0]           rdata,
    output logic [DATA_W-1:0]           wdata,
    output logic [N_MEM-1:0]            mem_valid,
    input  logic [N_MEM*DATAPATH_W-1:0] mem_bus,
    input  logic [N_DONE-1:0]           unit_done,
    input  logic [CONF_W-1:0]           config_bus,
    output logic [CONF_W-1:0]           config_shadow,
    output logic                        run,
    output logic                        busy
);

    localparam int AW = NMEM_W + MEM_ADDR_W + 1;

    state_e              state_q, state_d;
    logic                run_q, run_d;
    logic                pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic [CONF_W-1:0]   stage_q, stage_d;
    logic [CONF_W-1:0]   shadow_q, shadow_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;
    logic [CNT_W-1:0]    runs_q, runs_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                rd_q, ctl_q;
    logic [NMEM_W-1:0]   idx_q;
    logic [1:0]          reg_q;

    logic                ctrl_sp, ctrl_wr, run_req, clr_req;
    logic [NMEM_W-1:0]   idx;
    logic signed [DATAPATH_W-1:0] slice;
    logic [DATA_W-1:0]   status;
    logic                unused_bits;

    assign ctrl_sp = addr[AW-1];
    assign idx     = addr[AW-2 -: NMEM_W];
    assign ctrl_wr = valid & we & ctrl_sp & (addr[1:0] == REG_CTRL);
    assign run_req = ctrl_wr & rdata[CTRL_RUN];
    assign clr_req = ctrl_wr & rdata[CTRL_CLR];

    assign unused_bits = ^{addr[MEM_ADDR_W-1:2], rdata[DATA_W-1:2]};

    assign busy          = (state_q != S_IDLE) | pend_q;
    assign run           = run_q;
    assign config_shadow = shadow_q;

    always_comb begin
        mem_valid = '0;
        for (int j = 0; j < N_MEM; j++) begin
            mem_valid[j] = valid & ~ctrl_sp & (idx == NMEM_W'(j));
        end
    end

    // Clear is folded into pend_d/ovf_d first, so a run in the
    // same write sees the cleared state.
    always_comb begin
        state_d  = state_q;
        run_d    = 1'b0;
        pend_d   = pend_q & ~clr_req;
        ovf_d    = ovf_q & ~clr_req;
        stage_d  = stage_q;
        shadow_d = shadow_q;
        cycles_d = cycles_q;
        runs_d   = runs_q;
        if (run_req) begin
            if (pend_d) begin
                ovf_d = 1'b1;
            end else if (state_q == S_IDLE) begin
                run_d    = 1'b1;
                shadow_d = config_bus;
                state_d  = S_ARM;
            end else begin
                pend_d  = 1'b1;
                stage_d = config_bus;
            end
        end
        unique case (state_q)
            S_IDLE: begin
            end
            S_ARM: state_d = S_WAIT;
            S_WAIT: begin
                if (&unit_done) begin
                    cycles_d = cnt_q;
                    runs_d   = runs_q + 1'b1;
                    if (pend_d) begin
                        run_d    = 1'b1;
                        shadow_d = stage_d;
                        pend_d   = 1'b0;
                        state_d  = S_ARM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            run_q    <= 1'b0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
            stage_q  <= '0;
            shadow_q <= '0;
            cycles_q <= '0;
            runs_q   <= '0;
            rd_q     <= 1'b0;
            ctl_q    <= 1'b0;
            idx_q    <= '0;
            reg_q    <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            stage_q  <= stage_d;
            shadow_q <= shadow_d;
            cycles_q <= cycles_d;
            runs_q   <= runs_d;
            rd_q     <= valid & ~we;
            ctl_q    <= ctrl_sp;
            idx_q    <= idx;
            reg_q    <= addr[1:0];
        end
    end

    // Count is 1 in the pulse cycle, so CYCLES spans pulse..done.
    xsat_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (run_d),
        .en  (state_q != S_IDLE),
        .q   (cnt_q)
    );

    always_comb begin
        slice = '0;
        for (int j = 0; j < N_MEM; j++) begin
            if (idx_q == NMEM_W'(j)) begin
                slice = mem_bus[(N_MEM-1-j)*DATAPATH_W +: DATAPATH_W];
            end
        end
    end

    always_comb begin
        status          = '0;
        status[ST_DONE] = ~busy;
        status[ST_BUSY] = busy;
        status[ST_PEND] = pend_q;
        status[ST_OVF]  = ovf_q;
        wdata           = '0;
        if (rd_q) begin
            if (ctl_q) begin
                unique case (reg_q)
                    REG_CTRL:   wdata = status;
                    REG_CYCLES: wdata = DATA_W'(cycles_q);
                    REG_RUNS:   wdata = DATA_W'(runs_q);
                    REG_ZERO:   wdata = '0;
                endcase
            end else begin
                wdata = DATA_W'(slice);
            end
        end
    end

endmodule

// File: tb/tb_xeng_ctrl.sv
// Randomized scoreboard bench for xeng_ctrl with a
// timestamp-based run model.
module tb_xeng_ctrl;

    localparam int DW  = 32;
    localparam int PW  = 16;
    localparam int NM  = 4;
    localparam int NW  = 3;
    localparam int MAW = 10;
    localparam int ND  = 4;
    localparam int CW  = 256;
    localparam int KW  = 32;
    localparam int AW  = NW + MAW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] wdata;
    logic [NM-1:0] mem_valid;
    logic [NM*PW-1:0] mem_bus = '0;
    logic [ND-1:0] unit_done = '0;
    logic [CW-1:0] config_bus = '0;
    logic [CW-1:0] config_shadow;
    logic          run, busy;

    xeng_ctrl #(
        .DATA_W(DW), .DATAPATH_W(PW), .N_MEM(NM), .NMEM_W(NW),
        .MEM_ADDR_W(MAW), .N_DONE(ND), .CONF_W(CW), .CNT_W(KW)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid), .we(we), .addr(addr),
        .rdata(rdata), .wdata(wdata), .mem_valid(mem_valid),
        .mem_bus(mem_bus), .unit_done(unit_done),
        .config_bus(config_bus), .config_shadow(config_shadow),
        .run(run), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    bit m_act, m_pend, m_ovf;
    int m_tp;
    logic [CW-1:0] m_shadow, m_stage;
    logic [KW-1:0] m_cycles, m_runs;

    typedef struct {
        int            t;
        logic [CW-1:0] cfg;
    } pulse_t;
    pulse_t pq[$];
    logic [DW-1:0] rq[$];

    bit ovr_en = 1'b0;
    logic [DW-1:0] ovr_val = '0;
    bit last_rd = 1'b0;

    task automatic check(string name, logic [CW-1:0] act, logic [CW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_busy();
        return m_act | m_pend;
    endfunction

    function automatic void launch(logic [CW-1:0] c);
        pulse_t p;
        m_shadow = c;
        m_act    = 1'b1;
        m_tp     = cyc + 1;
        p.t      = cyc + 1;
        p.cfg    = c;
        pq.push_back(p);
    endfunction

    function automatic logic [DW-1:0] model_rd(logic [AW-1:0] a);
        logic [PW-1:0] s;
        int i;
        if (a[AW-1]) begin
            case (a[1:0])
                2'd0: return {28'd0, m_ovf, m_pend, m_busy(), !m_busy()};
                2'd1: return m_cycles;
                2'd2: return m_runs;
                default: return '0;
            endcase
        end
        i = int'(a[AW-2 -: NW]);
        if (i >= NM) return '0;
        s = mem_bus[(NM-1-i)*PW +: PW];
        return {{(DW-PW){s[PW-1]}}, s};
    endfunction

    function automatic logic [NM-1:0] exp_mv();
        logic [NM-1:0] m;
        int i;
        m = '0;
        i = int'(addr[AW-2 -: NW]);
        if (valid && !addr[AW-1] && i < NM) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [CW-1:0] rnd_cfg();
        logic [CW-1:0] c;
        for (int i = 0; i < CW/32; i++) c[i*32 +: 32] = $urandom;
        return c;
    endfunction

    task automatic model_reset();
        m_act = 0; m_pend = 0; m_ovf = 0; m_tp = 0;
        m_shadow = '0; m_stage = '0; m_cycles = '0; m_runs = '0;
        rq.delete();
        pq.delete();
    endtask

    // Model update for the cycle that just ended (index cyc).
    task automatic step();
        bit ctl, req;
        ctl = valid && we && addr[AW-1] && (addr[1:0] == 2'd0);
        req = ctl && rdata[0];
        if (ctl && rdata[1]) begin
            m_pend = 0;
            m_ovf  = 0;
        end
        if (req) begin
            if (m_pend) m_ovf = 1;
            else if (!m_act) launch(config_bus);
            else begin
                m_pend  = 1;
                m_stage = config_bus;
            end
        end
        if (m_act && cyc > m_tp && (&unit_done)) begin
            m_cycles = KW'(cyc - m_tp + 1);
            m_runs   = m_runs + 1;
            if (m_pend) begin
                m_pend = 0;
                launch(m_stage);
            end else begin
                m_act = 0;
            end
        end
        if (valid && !we) rq.push_back(ovr_en ? ovr_val : model_rd(addr));
    endtask

    task automatic tick();
        @(posedge clk);
        step();
        cyc++;
        #1;
        valid  = 1'b0;
        we     = 1'b0;
        ovr_en = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic wr_ctrl(logic [1:0] r, logic [DW-1:0] d);
        valid = 1; we = 1; addr = '0;
        addr[AW-1] = 1'b1; addr[1:0] = r; rdata = d;
        tick();
    endtask

    task automatic rd_ctrl(logic [1:0] r, bit oe, logic [DW-1:0] ov);
        valid = 1; we = 0; addr = '0;
        addr[AW-1] = 1'b1; addr[1:0] = r;
        ovr_en = oe; ovr_val = ov;
        tick();
    endtask

    task automatic rd_mem(int i, bit oe, logic [DW-1:0] ov);
        valid = 1; we = 0; addr = '0;
        addr[AW-2 -: NW] = NW'(i);
        addr[MAW-1:0] = MAW'($urandom);
        ovr_en = oe; ovr_val = ov;
        tick();
    endtask

    // Called right after a tick; rst is released before the next edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        check("rst_busy", busy, 0);
        check("rst_run", run, 0);
        check("rst_shadow", config_shadow, 0);
        check("rst_wdata", wdata, 0);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        pulse_t p;
        if (!rst) begin
            check("busy", busy, m_busy());
            check("shadow", config_shadow, m_shadow);
            check("mem_valid", mem_valid, exp_mv());
            if (rq.size() > 0) check("rd_data", wdata, rq.pop_front());
            if (run) begin
                if (pq.size() == 0) begin
                    check("run_extra", run, 0);
                end else begin
                    p = pq.pop_front();
                    check("run_cycle", cyc, p.t);
                    check("run_cfg", config_shadow, p.cfg);
                end
            end else if (pq.size() > 0 && pq[0].t <= cyc) begin
                void'(pq.pop_front());
                check("run_missing", run, 1);
            end
        end
    end

    initial begin
        int a;
        logic [CW-1:0] cfg_a5, cfg_3c;
        cfg_a5 = {8{32'hA5A5A5A5}};
        cfg_3c = {8{32'h3C3C3C3C}};
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        rd_ctrl(2'd0, 1, 32'h1);

        // reset in the middle of WAIT
        config_bus = cfg_a5;
        wr_ctrl(2'd0, 32'h1);
        idle(3);
        do_reset();
        rd_ctrl(2'd0, 1, 32'h1);
        rd_ctrl(2'd2, 1, 32'h0);

        // single run, done five cycles after the write
        config_bus = cfg_a5;
        unit_done = '0;
        wr_ctrl(2'd0, 32'h1);
        config_bus = rnd_cfg();
        idle(4);
        unit_done = '1;
        tick();
        unit_done = '0;
        rd_ctrl(2'd1, 1, 32'd5);
        rd_ctrl(2'd2, 1, 32'd1);
        rd_ctrl(2'd0, 1, 32'h1);

        // queued run
        do_reset();
        config_bus = cfg_a5;
        wr_ctrl(2'd0, 32'h1);
        tick();
        config_bus = cfg_3c;
        wr_ctrl(2'd0, 32'h1);
        rd_ctrl(2'd0, 1, 32'h6);
        unit_done = '1;
        tick();
        unit_done = '0;
        idle(3);
        unit_done = '1;
        tick();
        unit_done = '0;
        rd_ctrl(2'd2, 1, 32'd2);
        rd_ctrl(2'd0, 1, 32'h1);

        // overflow and clear
        do_reset();
        config_bus = cfg_a5;
        wr_ctrl(2'd0, 32'h1);
        tick();
        repeat (3) begin
            config_bus = rnd_cfg();
            wr_ctrl(2'd0, 32'h1);
        end
        rd_ctrl(2'd0, 1, 32'hE);
        unit_done = '1;
        tick();
        unit_done = '0;
        idle(2);
        wr_ctrl(2'd0, 32'h2);
        rd_ctrl(2'd0, 1, 32'h2);
        unit_done = '1;
        tick();
        unit_done = '0;
        rd_ctrl(2'd0, 1, 32'h1);

        // memory reads
        mem_bus = {$urandom, $urandom};
        mem_bus[16 +: 16] = 16'h8001;
        rd_mem(2, 1, 32'hFFFF8001);
        rd_mem(5, 1, 32'h0);
        rd_mem(0, 0, '0);
        tick();

        for (int k = 0; k < 3000; k++) begin
            unit_done = ($urandom_range(0, 4) == 0) ? '1 : ND'($urandom);
            if (!last_rd && $urandom_range(0, 3) == 0) mem_bus = {$urandom, $urandom};
            last_rd = 1'b0;
            a = $urandom_range(0, 19);
            if (a < 4) begin
                config_bus = rnd_cfg();
                wr_ctrl((a == 0) ? 2'($urandom) : 2'd0, DW'($urandom));
            end else if (a < 7) begin
                rd_ctrl(2'($urandom), 0, '0);
                last_rd = 1'b1;
            end else if (a < 9) begin
                rd_mem($urandom_range(0, 7), 0, '0);
                last_rd = 1'b1;
            end else if (a == 9) begin
                valid = 1; we = 1; addr = AW'($urandom);
                addr[AW-1] = 1'b0;
                tick();
            end else if (a == 10 && $urandom_range(0, 99) == 0) begin
                tick();
                do_reset();
            end else begin
                tick();
            end
        end
        unit_done = '0;
        idle(2);
        check("pulses_left", pq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
